// File: rtl/shift_register_load_ctrl_pkg.sv
// Shared types and helpers for the address/data shift-register loader.
// State encoding and word-count arithmetic live here.
package shift_register_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam state_t IDLE   = ST_IDLE;
  localparam state_t ACCEPT = ST_ACCEPT;
  localparam state_t SHIFT  = ST_SHIFT;
  localparam state_t COMMIT = ST_COMMIT;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/shift_register_load_ctrl.sv
// Loads a frame of stream words into the address/data shift register,
// one registered sr_shift pulse per word, then holds a commit handshake.
module shift_register_load_ctrl
  import shift_register_load_ctrl_pkg::*;
#(
  parameter int DATA_INPUT_WIDTH = 16,
  parameter int DATA_WIDTH       = 256,
  parameter int ADDRESS_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        data_only,
  input  logic                        abort,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_INPUT_WIDTH-1:0] s_data,
  output logic [DATA_INPUT_WIDTH-1:0] sr_in,
  output logic                        sr_select_data,
  output logic                        sr_shift,
  output logic                        commit_valid,
  input  logic                        commit_ready,
  output logic                        busy
);

  localparam int DATA_WORDS =
    ceil_div(DATA_WIDTH, DATA_INPUT_WIDTH);
  localparam int ADDR_WORDS =
    ceil_div(ADDRESS_WIDTH, DATA_INPUT_WIDTH);
  localparam int TOT_WORDS = ADDR_WORDS + DATA_WORDS;
  localparam int CNT_W = $clog2(TOT_WORDS + 1);

  localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(TOT_WORDS);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [DATA_INPUT_WIDTH-1:0] r_sr_in;
  logic                        r_sel;
  logic                        r_shift;
  logic                        r_ready;
  logic                        r_commit;
  logic                        r_busy;

  state_t                      w_state_nx;
  logic [CNT_W-1:0]            w_cnt_nx;
  logic [DATA_INPUT_WIDTH-1:0] w_sr_in_nx;
  logic                        w_sel_nx;
  logic                        w_shift_nx;
  logic                        w_commit_nx;

  // Every output is the registered image of the next-state decode.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_sr_in_nx  = r_sr_in;
    w_sel_nx    = r_sel;
    w_shift_nx  = 1'b0;
    w_commit_nx = r_commit;
    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_nx = ACCEPT;
          w_cnt_nx   = data_only ? CNT_DATA : CNT_ALL;
        end
      end
      ACCEPT: begin
        if (abort) begin
          w_state_nx = IDLE;
        end else if (s_valid) begin
          w_sr_in_nx = s_data;
          w_sel_nx   = (r_cnt <= CNT_DATA);
          w_state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nx = IDLE;
        end else begin
          w_shift_nx = 1'b1;
          w_cnt_nx   = r_cnt - CNT_ONE;
          w_state_nx = (r_cnt == CNT_ONE) ? COMMIT : ACCEPT;
        end
      end
      COMMIT: begin
        if (abort) begin
          w_state_nx  = IDLE;
          w_commit_nx = 1'b0;
        end else if (!r_commit) begin
          w_commit_nx = 1'b1;
        end else if (commit_ready) begin
          w_state_nx  = IDLE;
          w_commit_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx  = IDLE;
        w_commit_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sr_in  <= '0;
      r_sel    <= 1'b0;
      r_shift  <= 1'b0;
      r_ready  <= 1'b0;
      r_commit <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_sr_in  <= w_sr_in_nx;
      r_sel    <= w_sel_nx;
      r_shift  <= w_shift_nx;
      r_ready  <= (w_state_nx == ACCEPT);
      r_commit <= w_commit_nx;
      r_busy   <= (w_state_nx != IDLE);
    end
  end

  assign s_ready        = r_ready;
  assign sr_in          = r_sr_in;
  assign sr_select_data = r_sel;
  assign sr_shift       = r_shift;
  assign commit_valid   = r_commit;
  assign busy           = r_busy;

endmodule
